// File: rtl/pwm_sample_scheduler.sv
// Sample scheduler between the signal mixer and the PWM stage: buffers mixer
// samples in a small FIFO and hands exactly one sample to the PWM per period.
module pwm_sample_scheduler #(
    parameter int DEPTH       = 4,
    parameter int PRIME_LEVEL = 2,
    parameter int PERIOD      = 256
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     enable,
    input  logic [7:0]               sample_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic                     pwm_start,
    output logic [7:0]               pwm_sample,
    output logic                     period_tick,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   fill_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST_COUNT = CW'(PERIOD - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   PRIME_FILL = (AW + 1)'(PRIME_LEVEL);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [7:0]    sample_q, sample_d;
    logic          tick_q, tick_d;
    logic          under_q, under_d;
    logic [7:0]    mem_q [DEPTH];

    logic          full;
    logic          push;
    logic          pop;
    logic          flush;
    logic          at_last;
    logic [AW:0]   fill_after_push;
    logic [7:0]    head;

    assign full            = (fill_q == FULL_LEVEL);
    assign at_last         = (count_q == LAST_COUNT);
    assign sample_ready    = ((state_q == PRIME) || (state_q == RUN)) && !full;
    assign push            = sample_valid && sample_ready;
    assign fill_after_push = fill_q + (AW + 1)'(push);
    // With PRIME_LEVEL of 1 the priming pop can find the FIFO empty, so the incoming sample is forwarded.
    assign head            = (fill_q == '0) ? sample_in : mem_q[rd_q];

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = PRIME;
            end
            PRIME: begin
                if (!enable) state_d = IDLE;
                else if (fill_after_push >= PRIME_FILL) state_d = RUN;
            end
            RUN: begin
                if (!enable) state_d = DRAIN;
            end
            DRAIN: begin
                if (at_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flush    = 1'b0;
        pop      = 1'b0;
        count_d  = '0;
        sample_d = sample_q;
        case (state_q)
            IDLE: begin
                sample_d = '0;
            end
            PRIME: begin
                if (!enable) begin
                    flush = 1'b1;
                end else if (fill_after_push >= PRIME_FILL) begin
                    pop      = 1'b1;
                    sample_d = head;
                end
            end
            RUN: begin
                count_d = at_last ? '0 : count_q + 1'b1;
                if (at_last && (fill_q != '0)) begin
                    pop      = 1'b1;
                    sample_d = head;
                end
            end
            DRAIN: begin
                count_d = at_last ? '0 : count_q + 1'b1;
                if (at_last) begin
                    flush    = 1'b1;
                    sample_d = '0;
                end
            end
            default: begin
                flush = 1'b1;
            end
        endcase
    end

    // Pulse outputs are computed one edge early so they are flops aligned with the last period clock.
    always_comb begin
        if (flush) begin
            rd_d   = '0;
            wr_d   = '0;
            fill_d = '0;
        end else begin
            rd_d   = rd_q + AW'(pop);
            wr_d   = wr_q + AW'(push);
            fill_d = fill_after_push - (AW + 1)'(pop);
        end
        tick_d  = ((state_d == RUN) || (state_d == DRAIN)) && (count_d == LAST_COUNT);
        under_d = (state_d == RUN) && (count_d == LAST_COUNT) && (fill_d == '0);
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            count_q  <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            fill_q   <= '0;
            sample_q <= '0;
            tick_q   <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            fill_q   <= fill_d;
            sample_q <= sample_d;
            tick_q   <= tick_d;
            under_q  <= under_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= sample_in;
    end

    assign pwm_start   = (state_q == RUN) || (state_q == DRAIN);
    assign pwm_sample  = sample_q;
    assign period_tick = tick_q;
    assign underrun    = under_q;
    assign fill_level  = fill_q;

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Directed bench for pwm_sample_scheduler: a default instance plus a
// PRIME_LEVEL=4 instance used to exercise the full-FIFO back-pressure.
module tb_pwm_sample_scheduler;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;

    logic       enable, sample_valid;
    logic [7:0] sample_in;
    logic       sample_ready, pwm_start, period_tick, underrun;
    logic [7:0] pwm_sample;
    logic [2:0] fill_level;

    logic       enableB, validB;
    logic [7:0] dataB;
    logic       readyB, startB, tickB, underB;
    logic [7:0] sampleB;
    logic [2:0] fillB;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    pwm_sample_scheduler u_dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pwm_start    (pwm_start),
        .pwm_sample   (pwm_sample),
        .period_tick  (period_tick),
        .underrun     (underrun),
        .fill_level   (fill_level)
    );

    pwm_sample_scheduler #(.DEPTH(4), .PRIME_LEVEL(4), .PERIOD(256)) u_dutB (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (enableB),
        .sample_in    (dataB),
        .sample_valid (validB),
        .sample_ready (readyB),
        .pwm_start    (startB),
        .pwm_sample   (sampleB),
        .period_tick  (tickB),
        .underrun     (underB),
        .fill_level   (fillB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic valid, input logic [7:0] data);
        enable       = en;
        sample_valid = valid;
        sample_in    = data;
    endtask

    // Each step leaves the bench 1 time unit after a rising edge.
    task automatic stepClock(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        n_rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        enableB = 1'b0;
        validB  = 1'b0;
        dataB   = 8'h00;
        stepClock(2);
        checkOutput("rst_ready",  sample_ready, 0);
        checkOutput("rst_start",  pwm_start,    0);
        checkOutput("rst_sample", pwm_sample,   0);
        checkOutput("rst_tick",   period_tick,  0);
        checkOutput("rst_under",  underrun,     0);
        checkOutput("rst_fill",   fill_level,   0);
        n_rst = 1'b0;
    endtask

    initial begin
        // Priming and first boundary
        doReset();
        applyStimulus(1'b1, 1'b0, 8'h00);
        stepClock(1);
        checkOutput("prime_ready", sample_ready, 1);
        checkOutput("prime_start", pwm_start, 0);
        applyStimulus(1'b1, 1'b1, 8'h40);
        stepClock(1);
        checkOutput("prime_fill1", fill_level, 1);
        checkOutput("prime_start1", pwm_start, 0);
        applyStimulus(1'b1, 1'b1, 8'h80);
        stepClock(1);
        checkOutput("run_start", pwm_start, 1);
        checkOutput("run_first_sample", pwm_sample, 8'h40);
        checkOutput("run_fill", fill_level, 1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        stepClock(254);
        checkOutput("no_early_tick", period_tick, 0);
        stepClock(1);
        checkOutput("first_tick", period_tick, 1);
        checkOutput("first_tick_under", underrun, 0);
        checkOutput("sample_held", pwm_sample, 8'h40);
        stepClock(1);
        checkOutput("second_sample", pwm_sample, 8'h80);
        checkOutput("tick_one_cycle", period_tick, 0);
        checkOutput("fill_after_pop", fill_level, 0);

        // Push and pop on the same boundary edge
        applyStimulus(1'b1, 1'b1, 8'h11);
        stepClock(1);
        applyStimulus(1'b1, 1'b1, 8'h22);
        stepClock(1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        stepClock(253);
        checkOutput("pp_tick", period_tick, 1);
        checkOutput("pp_fill_before", fill_level, 2);
        applyStimulus(1'b1, 1'b1, 8'h33);
        stepClock(1);
        checkOutput("pp_fill_after", fill_level, 2);
        checkOutput("pp_sample", pwm_sample, 8'h11);
        applyStimulus(1'b1, 1'b0, 8'h00);
        stepClock(256);
        checkOutput("order_2", pwm_sample, 8'h22);
        checkOutput("order_2_fill", fill_level, 1);
        stepClock(256);
        checkOutput("order_3", pwm_sample, 8'h33);
        checkOutput("order_3_fill", fill_level, 0);

        // Underrun: boundary with an empty FIFO
        stepClock(255);
        checkOutput("underrun_pulse", underrun, 1);
        checkOutput("underrun_tick", period_tick, 1);
        checkOutput("underrun_hold", pwm_sample, 8'h33);
        stepClock(1);
        checkOutput("underrun_clear", underrun, 0);
        checkOutput("underrun_hold2", pwm_sample, 8'h33);
        checkOutput("underrun_still_run", pwm_start, 1);
        checkOutput("underrun_ready", sample_ready, 1);

        // Drain: drop enable at counter 100, reassert inside DRAIN
        applyStimulus(1'b1, 1'b1, 8'h55);
        stepClock(1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        stepClock(99);
        applyStimulus(1'b0, 1'b0, 8'h00);
        stepClock(1);
        checkOutput("drain_ready", sample_ready, 0);
        checkOutput("drain_start", pwm_start, 1);
        checkOutput("drain_sample", pwm_sample, 8'h33);
        checkOutput("drain_fill", fill_level, 1);
        applyStimulus(1'b1, 1'b1, 8'h66);
        stepClock(154);
        checkOutput("drain_tick", period_tick, 1);
        checkOutput("drain_no_push", fill_level, 1);
        checkOutput("drain_no_under", underrun, 0);
        checkOutput("drain_start_last", pwm_start, 1);
        stepClock(1);
        checkOutput("idle_start", pwm_start, 0);
        checkOutput("idle_sample", pwm_sample, 0);
        checkOutput("idle_fill", fill_level, 0);
        checkOutput("idle_ready", sample_ready, 0);
        checkOutput("idle_tick", period_tick, 0);
        applyStimulus(1'b0, 1'b0, 8'h00);
        stepClock(2);

        // Asynchronous reset in RUN at counter 37 with 3 samples buffered
        doReset();
        applyStimulus(1'b1, 1'b0, 8'h00);
        stepClock(1);
        applyStimulus(1'b1, 1'b1, 8'hA1);
        stepClock(1);
        applyStimulus(1'b1, 1'b1, 8'hA2);
        stepClock(1);
        applyStimulus(1'b1, 1'b1, 8'hA3);
        stepClock(1);
        applyStimulus(1'b1, 1'b1, 8'hA4);
        stepClock(1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        stepClock(35);
        checkOutput("pre_rst_fill", fill_level, 3);
        checkOutput("pre_rst_sample", pwm_sample, 8'hA1);
        n_rst = 1'b1;
        #1;
        checkOutput("async_start", pwm_start, 0);
        checkOutput("async_sample", pwm_sample, 0);
        checkOutput("async_fill", fill_level, 0);
        checkOutput("async_ready", sample_ready, 0);
        checkOutput("async_tick", period_tick, 0);
        #2;
        n_rst = 1'b0;
        stepClock(1);
        checkOutput("reprime_ready", sample_ready, 1);
        checkOutput("reprime_fill0", fill_level, 0);
        applyStimulus(1'b1, 1'b1, 8'hB1);
        stepClock(1);
        checkOutput("reprime_fill1", fill_level, 1);
        checkOutput("reprime_wait", pwm_start, 0);
        applyStimulus(1'b1, 1'b1, 8'hB2);
        stepClock(1);
        checkOutput("reprime_run", pwm_start, 1);
        checkOutput("reprime_sample", pwm_sample, 8'hB1);
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Full FIFO back-pressure on the PRIME_LEVEL=4 instance
        doReset();
        enableB = 1'b1;
        stepClock(1);
        for (int i = 1; i <= 3; i++) begin
            dataB  = 8'(i);
            validB = 1'b1;
            stepClock(1);
            checkOutput("b_prime_fill", fillB, i);
            checkOutput("b_prime_start", startB, 0);
        end
        dataB = 8'h04;
        stepClock(1);
        checkOutput("b_run_start", startB, 1);
        checkOutput("b_run_sample", sampleB, 8'h01);
        checkOutput("b_run_fill", fillB, 3);
        checkOutput("b_run_ready", readyB, 1);
        dataB = 8'h05;
        stepClock(1);
        checkOutput("b_full_fill", fillB, 4);
        checkOutput("b_full_ready", readyB, 0);
        dataB = 8'h06;
        stepClock(10);
        checkOutput("b_hold_fill", fillB, 4);
        checkOutput("b_hold_ready", readyB, 0);
        stepClock(244);
        checkOutput("b_tick", tickB, 1);
        checkOutput("b_tick_fill", fillB, 4);
        stepClock(1);
        checkOutput("b_pop_sample", sampleB, 8'h02);
        checkOutput("b_pop_fill", fillB, 3);
        checkOutput("b_pop_ready", readyB, 1);
        stepClock(1);
        checkOutput("b_refill", fillB, 4);
        validB = 1'b0;
        stepClock(255);
        checkOutput("b_wrap_3", sampleB, 8'h03);
        checkOutput("b_wrap_3_fill", fillB, 3);
        stepClock(256);
        checkOutput("b_wrap_4", sampleB, 8'h04);
        stepClock(256);
        checkOutput("b_wrap_5", sampleB, 8'h05);
        stepClock(256);
        checkOutput("b_wrap_6", sampleB, 8'h06);
        checkOutput("b_wrap_6_fill", fillB, 0);
        enableB = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
